// File: rtl/vertex_cache_miss_queue_if.sv
// Purpose: groups the miss-command, memory-command, completion and status signals of the miss queue.
// Latency: none, wires only.
// Backpressure: the miss side has none; the memory side uses mem_cmd_valid_out / mem_cmd_ready_in.
// Ports (slave = the queue):
//   enabled_in, miss_cmd_valid_in, miss_cmd_payload_in, mem_cmd_ready_in, mem_rsp_done_in -> queue
//   mem_cmd_valid_out, mem_cmd_payload_out, almost_full_out, empty_out, outstanding_out, error_out <- queue
interface vertex_cache_miss_queue_if #(
   parameter int CMD_BITS        = 128,
   parameter int MAX_OUTSTANDING = 8
);
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

   logic                enabled_in;
   logic                miss_cmd_valid_in;
   logic [CMD_BITS-1:0] miss_cmd_payload_in;
   logic                mem_cmd_ready_in;
   logic                mem_cmd_valid_out;
   logic [CMD_BITS-1:0] mem_cmd_payload_out;
   logic                mem_rsp_done_in;
   logic                almost_full_out;
   logic                empty_out;
   logic [OUT_W-1:0]    outstanding_out;
   logic [1:0]          error_out;

   modport slave (
      input  enabled_in, miss_cmd_valid_in, miss_cmd_payload_in, mem_cmd_ready_in, mem_rsp_done_in,
      output mem_cmd_valid_out, mem_cmd_payload_out, almost_full_out, empty_out, outstanding_out,
             error_out
   );

   modport master (
      output enabled_in, miss_cmd_valid_in, miss_cmd_payload_in, mem_cmd_ready_in, mem_rsp_done_in,
      input  mem_cmd_valid_out, mem_cmd_payload_out, almost_full_out, empty_out, outstanding_out,
             error_out
   );
endinterface

// File: rtl/vertex_cache_miss_queue.sv
// Purpose: buffers vertex-cache miss commands and issues them as memory reads, bounding reads in flight.
// Latency: a push into an empty queue is presented on mem_cmd_valid_out one cycle later (no bypass).
// Backpressure: none on the miss side (drop + sticky error at full); memory side is valid/ready.
// Ports:
//   clock, rst_in : single clock, synchronous active-high reset
//   bus (slave)   : miss command in, memory command out, completion pulses, status/errors
module vertex_cache_miss_queue #(
   parameter int QUEUE_DEPTH     = 16,
   parameter int CMD_BITS        = 128,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                       clock,
   input  logic                       rst_in,
   vertex_cache_miss_queue_if.slave   bus
);
   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(QUEUE_DEPTH);
   localparam logic [OCC_W-1:0] OCC_AFULL = OCC_W'(QUEUE_DEPTH - 4);
   localparam logic [OUT_W-1:0] OUT_MAX   = OUT_W'(MAX_OUTSTANDING);

   // Payload storage is never reset; only pointers/counters define validity.
   logic [CMD_BITS-1:0] ram_q [QUEUE_DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] occ_q,    occ_d;
   logic [OUT_W-1:0] outst_q,  outst_d;
   logic [1:0]       err_q,    err_d;

   logic issue_vld;
   logic pop;
   logic push;
   logic overflow;
   logic done_ok;
   logic underflow;

   always_comb begin
      issue_vld = (occ_q != '0) && bus.enabled_in && (outst_q < OUT_MAX);
      pop       = issue_vld && bus.mem_cmd_ready_in;
      // A same-cycle pop frees the slot, so a push at full still succeeds.
      push      = bus.miss_cmd_valid_in && ((occ_q != OCC_FULL) || pop);
      overflow  = bus.miss_cmd_valid_in && !push;
      done_ok   = bus.mem_rsp_done_in && (outst_q != '0);
      underflow = bus.mem_rsp_done_in && (outst_q == '0);

      // Power-of-two depth: pointers wrap naturally.
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

      occ_d = occ_q;
      unique case ({push, pop})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase

      // An ignored done (count already zero) never decrements.
      outst_d = outst_q;
      unique case ({pop, done_ok})
         2'b10:   outst_d = outst_q + OUT_W'(1);
         2'b01:   outst_d = outst_q - OUT_W'(1);
         default: outst_d = outst_q;
      endcase

      err_d = err_q | {underflow, overflow};
   end

   always_ff @(posedge clock) begin
      if (rst_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         outst_q  <= '0;
         err_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         outst_q  <= outst_d;
         err_q    <= err_d;
      end
   end

   // A push during reset is harmless: the pointers are cleared, so the entry is never read.
   always_ff @(posedge clock) begin
      if (push) begin
         ram_q[wr_ptr_q] <= bus.miss_cmd_payload_in;
      end
   end

   assign bus.mem_cmd_valid_out   = issue_vld;
   assign bus.mem_cmd_payload_out = ram_q[rd_ptr_q];
   assign bus.almost_full_out     = (occ_q >= OCC_AFULL);
   assign bus.empty_out           = (occ_q == '0);
   assign bus.outstanding_out     = outst_q;
   assign bus.error_out           = err_q;
endmodule

// File: tb/tb_vertex_cache_miss_queue.sv
module tb_vertex_cache_miss_queue;
   localparam int DEPTH = 16;
   localparam int CB    = 128;
   localparam int MAXO  = 8;

   logic clock = 1'b0;
   logic rst_in = 1'b1;
   always #5 clock = ~clock;

   vertex_cache_miss_queue_if #(.CMD_BITS(CB), .MAX_OUTSTANDING(MAXO)) bus ();

   vertex_cache_miss_queue #(
      .QUEUE_DEPTH(DEPTH), .CMD_BITS(CB), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clock (clock),
      .rst_in(rst_in),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int issues_seen = 0;

   // Reference model: queue contents, reads in flight, sticky errors.
   logic [CB-1:0] mq[$];
   logic [CB-1:0] sb[$];
   int            m_out = 0;
   logic [1:0]    m_err = 2'b00;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every issue handshake must match the next expected payload.
   initial begin
      logic [CB-1:0] exp;
      forever begin
         @(negedge clock);
         if (rst_in === 1'b0 && bus.mem_cmd_valid_out === 1'b1 && bus.mem_cmd_ready_in === 1'b1) begin
            issues_seen++;
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL issue_order: got payload %0h expected no issue", bus.mem_cmd_payload_out);
            end else begin
               exp = sb.pop_front();
               if (bus.mem_cmd_payload_out !== exp) begin
                  n_fail++;
                  $display("FAIL issue_order: got payload %0h expected %0h", bus.mem_cmd_payload_out, exp);
               end
            end
         end
      end
   end

   // One cycle: drive inputs, compare status against the model, then advance the model
   // with what the upcoming edge will do.
   task automatic step(input bit rst, input bit en, input bit mv, input logic [CB-1:0] p,
                       input bit rdy, input bit done);
      bit m_vld, pop, push;
      int o;
      logic [CB-1:0] tmp;
      @(posedge clock);
      #1;
      rst_in                  = rst;
      bus.enabled_in          = en;
      bus.miss_cmd_valid_in   = mv;
      bus.miss_cmd_payload_in = p;
      bus.mem_cmd_ready_in    = rdy;
      bus.mem_rsp_done_in     = done;
      #1;
      m_vld = (mq.size() > 0) && en && (m_out < MAXO);
      chk("valid",       bus.mem_cmd_valid_out, m_vld);
      chk("empty",       bus.empty_out, mq.size() == 0);
      chk("almost_full", bus.almost_full_out, mq.size() >= DEPTH - 4);
      chk("outstanding", bus.outstanding_out, m_out);
      chk("error",       bus.error_out, m_err);
      if (rst) begin
         mq.delete();
         sb.delete();
         m_out = 0;
         m_err = 2'b00;
      end else begin
         pop  = m_vld && rdy;
         push = mv && ((mq.size() < DEPTH) || pop);
         o = m_out;
         if (pop) begin
            tmp = mq.pop_front();
            o++;
         end
         if (push) begin
            mq.push_back(p);
            sb.push_back(p);
         end else if (mv) begin
            m_err[0] = 1'b1;
         end
         if (done) begin
            if (m_out > 0) o--;
            else m_err[1] = 1'b1;
         end
         m_out = o;
      end
   endtask

   task automatic idle(input bit rdy);
      step(0, 1, 0, '0, rdy, 0);
   endtask

   initial begin
      int base;
      logic [CB-1:0] rp;

      bus.enabled_in = 1'b0; bus.miss_cmd_valid_in = 1'b0; bus.miss_cmd_payload_in = '0;
      bus.mem_cmd_ready_in = 1'b0; bus.mem_rsp_done_in = 1'b0;
      rst_in = 1'b1;
      repeat (2) @(posedge clock);
      #2;
      chk("rst_valid", bus.mem_cmd_valid_out, 1'b0);
      chk("rst_empty", bus.empty_out, 1'b1);
      chk("rst_afull", bus.almost_full_out, 1'b0);
      chk("rst_outst", bus.outstanding_out, 0);
      chk("rst_error", bus.error_out, 2'b00);

      // Three pushes issued in order, one-cycle latency.
      step(1, 1, 0, '0, 0, 0);
      base = issues_seen;
      step(0, 1, 1, CB'(8'hA1), 1, 0);
      chk("lat_valid_before", bus.mem_cmd_valid_out, 1'b0);
      step(0, 1, 1, CB'(8'hA2), 1, 0);
      chk("lat_valid_after", bus.mem_cmd_valid_out, 1'b1);
      step(0, 1, 1, CB'(8'hA3), 1, 0);
      repeat (3) idle(1);
      chk("three_outst", bus.outstanding_out, 3);
      chk("three_issued", issues_seen - base, 3);
      repeat (3) step(0, 1, 0, '0, 0, 1);

      // Overflow with ready held low, then in-order drain.
      step(1, 1, 0, '0, 0, 0);
      base = issues_seen;
      for (int i = 1; i <= 17; i++) begin
         step(0, 1, 1, CB'(i), 0, 0);
         if (i == 12) chk("afull_at_11", bus.almost_full_out, 1'b0);
         if (i == 13) chk("afull_at_12", bus.almost_full_out, 1'b1);
      end
      idle(0);
      chk("overflow_err", bus.error_out, 2'b01);
      for (int i = 0; i < 80 && (mq.size() > 0 || m_out > 0); i++) step(0, 1, 0, '0, 1, m_out > 0);
      chk("drain_count", issues_seen - base, 16);

      // Outstanding limit stalls issue; one completion releases exactly one more.
      step(1, 1, 0, '0, 0, 0);
      for (int i = 0; i < 16; i++) step(0, 1, 1, CB'(32'hB000 + i), 0, 0);
      base = issues_seen;
      repeat (12) idle(1);
      chk("limit_valid", bus.mem_cmd_valid_out, 1'b0);
      chk("limit_outst", bus.outstanding_out, MAXO);
      chk("limit_not_empty", bus.empty_out, 1'b0);
      chk("limit_issued", issues_seen - base, 8);
      step(0, 1, 0, '0, 1, 1);
      repeat (4) idle(1);
      chk("release_one", issues_seen - base, 9);
      chk("release_outst", bus.outstanding_out, MAXO);

      // Pop+done at 5 outstanding; push+pop at full.
      step(1, 1, 0, '0, 0, 0);
      for (int i = 0; i < 16; i++) step(0, 1, 1, CB'(32'hC000 + i), 0, 0);
      for (int i = 0; i < 20 && m_out < 5; i++) idle(1);
      step(0, 1, 0, '0, 1, 1);
      idle(0);
      chk("popdone_outst", bus.outstanding_out, 5);
      for (int i = 0; i < 6; i++) step(0, 1, 1, CB'(32'hC100 + i), 0, 0);
      step(0, 1, 1, CB'(32'hC200), 1, 0);
      idle(0);
      chk("full_pushpop_err", bus.error_out, 2'b00);
      chk("full_pushpop_afull", bus.almost_full_out, 1'b1);
      step(0, 1, 1, CB'(32'hC300), 0, 0);
      idle(0);
      chk("still_full", bus.error_out, 2'b01);

      // Done with nothing outstanding.
      step(1, 1, 0, '0, 0, 0);
      step(0, 1, 0, '0, 0, 1);
      idle(0);
      chk("underflow_outst", bus.outstanding_out, 0);
      chk("underflow_err", bus.error_out, 2'b10);

      // Reset mid-operation discards everything.
      step(1, 1, 0, '0, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 1, 1, CB'(32'hD000 + i), 0, 0);
      for (int i = 0; i < 20 && m_out < 4; i++) idle(1);
      idle(0);
      chk("pre_rst_outst", bus.outstanding_out, 4);
      step(1, 1, 0, '0, 0, 0);
      idle(1);
      chk("midrst_empty", bus.empty_out, 1'b1);
      chk("midrst_outst", bus.outstanding_out, 0);
      chk("midrst_valid", bus.mem_cmd_valid_out, 1'b0);
      step(0, 1, 0, '0, 0, 1);
      idle(0);
      chk("midrst_done_err", bus.error_out, 2'b10);

      // Randomized traffic.
      step(1, 1, 0, '0, 0, 0);
      for (int i = 0; i < 2000; i++) begin
         rp = {$urandom, $urandom, $urandom, $urandom};
         step($urandom_range(0, 199) == 0,
              $urandom_range(0, 9) < 8,
              $urandom_range(0, 9) < 6,
              rp,
              $urandom_range(0, 9) < 7,
              (m_out > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 99) < 3));
      end
      for (int i = 0; i < 80 && (mq.size() > 0 || m_out > 0); i++) step(0, 1, 0, '0, 1, m_out > 0);
      chk("final_sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
